// File: rtl/dds_sweep_pkg.sv
// Shared constants for the DDS sweep scheduler: FSM encoding, tuning-word width
// and the UPDATE strobe hold length.
package dds_sweep_pkg;

  localparam int FREQW_W     = 32;
  localparam int UPDATE_HOLD = 2;
  localparam int REQ_CNT_W   = $clog2(UPDATE_HOLD);

  typedef logic [3:0] state_t;

  localparam state_t IDLE   = 4'd0;
  localparam state_t INIT   = 4'd1;
  localparam state_t LOAD   = 4'd2;
  localparam state_t REQ    = 4'd3;
  localparam state_t WACK   = 4'd4;
  localparam state_t WDONE  = 4'd5;
  localparam state_t DWELL  = 4'd6;
  localparam state_t NEXT   = 4'd7;
  localparam state_t FINISH = 4'd8;

  // States that block on the updater and are therefore guarded by the timeout.
  function automatic logic is_wait_state(input state_t s);
    return (s == INIT) || (s == WACK) || (s == WDONE);
  endfunction

endpackage

// File: rtl/dds_sweep_scheduler_if.sv
// Handshake between the sweep scheduler (master) and the AD9911 frequency
// updater (slave).
interface dds_sweep_scheduler_if;
  import dds_sweep_pkg::*;

  logic               INIT_DDS;
  logic               INITIED;
  logic [FREQW_W-1:0] FREQW;
  logic               UPDATE;
  logic               UPDATED;

  modport master (output INIT_DDS, FREQW, UPDATE, input INITIED, UPDATED);
  modport slave  (input INIT_DDS, FREQW, UPDATE, output INITIED, UPDATED);
endinterface

// File: rtl/sweep_dwell_timer.sv
// Loadable down-counter with a zero flag; used both for step dwell and for
// the wait-state timeout.
module sweep_dwell_timer #(
  parameter int W = 24
) (
  input  logic         CLOCK_10M,
  input  logic         RESET_N,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic         zero
);

  logic [W-1:0] count;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge CLOCK_10M or negedge RESET_N) begin
    if (!RESET_N) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (en && (count != '0)) begin
      count <= count - W'(1);
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/dds_sweep_scheduler.sv
// Stepped frequency sweep sequencer for the AD9911 updater: init, one UPDATE per
// step, dwell, DONE. Define SWEEP_LOOP_EN to add the LOOP input (continuous sweep).
module dds_sweep_scheduler
  import dds_sweep_pkg::*;
#(
  parameter int CNT_W       = 16,
  parameter int DWELL_W     = 24,
  parameter int TIMEOUT_CYC = 65535
) (
  input  logic                 CLOCK_10M,
  input  logic                 RESET_N,
  input  logic                 START,
  input  logic                 ABORT,
  input  logic [FREQW_W-1:0]   START_FREQW,
  input  logic [FREQW_W-1:0]   STEP_FREQW,
  input  logic [CNT_W-1:0]     NUM_STEPS,
  input  logic [DWELL_W-1:0]   DWELL_CYC,
`ifdef SWEEP_LOOP_EN
  input  logic                 LOOP,
`endif
  dds_sweep_scheduler_if.master dds,
  output logic                 BUSY,
  output logic [CNT_W-1:0]     STEP_IDX,
  output logic                 STEP_TRIG,
  output logic                 DONE,
  output logic                 ERROR
);

  localparam int TO_W = $clog2(TIMEOUT_CYC + 1);

  state_t               state, state_nxt;
  logic                 start_q, start_rise;
  logic                 init_dds, update, timeout;
  logic [FREQW_W-1:0]   freqw, cur_freqw, step_freqw_q;
  logic [CNT_W-1:0]     k, num_steps_q;
  logic [DWELL_W-1:0]   dwell_q;
  logic [REQ_CNT_W-1:0] req_cnt;
  logic                 last_step, dw_zero, to_zero, to_load;
`ifdef SWEEP_LOOP_EN
  logic [FREQW_W-1:0]   start_freqw_q;
`endif

  assign start_rise   = START && !start_q;
  assign last_step    = (k == num_steps_q - CNT_W'(1));
  assign dds.INIT_DDS = init_dds;
  assign dds.FREQW    = freqw;
  assign dds.UPDATE   = update;

  // Timeout restarts on every state change so each wait state gets a full budget.
  assign to_load = !is_wait_state(state) || (state_nxt != state);

  sweep_dwell_timer #(.W(DWELL_W)) u_dwell (
    .CLOCK_10M (CLOCK_10M),
    .RESET_N   (RESET_N),
    .load      ((state == WDONE) && (state_nxt == DWELL)),
    .load_val  (dwell_q - DWELL_W'(1)),
    .en        (state == DWELL),
    .zero      (dw_zero)
  );

  sweep_dwell_timer #(.W(TO_W)) u_timeout (
    .CLOCK_10M (CLOCK_10M),
    .RESET_N   (RESET_N),
    .load      (to_load),
    .load_val  (TO_W'(TIMEOUT_CYC - 1)),
    .en        (is_wait_state(state)),
    .zero      (to_zero)
  );

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    state_nxt = state;
    timeout   = 1'b0;
    if (ABORT && (state != IDLE)) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:   if (start_rise && !ABORT && (NUM_STEPS != '0)) state_nxt = INIT;
        INIT:   if (init_dds && dds.INITIED) state_nxt = LOAD; else timeout = to_zero;
        LOAD:   state_nxt = REQ;
        REQ:    if (req_cnt == REQ_CNT_W'(UPDATE_HOLD - 1)) state_nxt = WACK;
        WACK:   if (!dds.UPDATED) state_nxt = WDONE; else timeout = to_zero;
        WDONE:  if (dds.UPDATED) state_nxt = (dwell_q == '0) ? NEXT : DWELL;
                else timeout = to_zero;
        DWELL:  if (dw_zero) state_nxt = NEXT;
        NEXT: begin
          state_nxt = last_step ? FINISH : LOAD;
`ifdef SWEEP_LOOP_EN
          if (last_step && LOOP) state_nxt = LOAD;
`endif
        end
        FINISH: state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
      if (timeout) state_nxt = IDLE;
    end
  end

  always_ff @(posedge CLOCK_10M or negedge RESET_N) begin
    if (!RESET_N) begin
      state        <= IDLE;
      start_q      <= 1'b0;
      init_dds     <= 1'b0;
      update       <= 1'b0;
      freqw        <= '0;
      cur_freqw    <= '0;
      step_freqw_q <= '0;
      num_steps_q  <= '0;
      dwell_q      <= '0;
      req_cnt      <= '0;
      k            <= '0;
      BUSY         <= 1'b0;
      STEP_IDX     <= '0;
      STEP_TRIG    <= 1'b0;
      DONE         <= 1'b0;
      ERROR        <= 1'b0;
`ifdef SWEEP_LOOP_EN
      start_freqw_q <= '0;
`endif
    end else begin
      start_q   <= START;
      STEP_TRIG <= 1'b0;
      DONE      <= 1'b0;
      state     <= state_nxt;
      if (ABORT && (state != IDLE)) begin
        // Dropping INIT_DDS resets the updater even mid-transaction.
        update   <= 1'b0;
        init_dds <= 1'b0;
        BUSY     <= 1'b0;
      end else if (timeout) begin
        ERROR    <= 1'b1;
        init_dds <= 1'b0;
        BUSY     <= 1'b0;
      end else begin
        case (state)
          IDLE: if (start_rise && !ABORT) begin
            ERROR <= 1'b0;
            if (NUM_STEPS == '0) begin
              DONE <= 1'b1;
            end else begin
              BUSY         <= 1'b1;
              k            <= '0;
              cur_freqw    <= START_FREQW;
              step_freqw_q <= STEP_FREQW;
              num_steps_q  <= NUM_STEPS;
              dwell_q      <= DWELL_CYC;
`ifdef SWEEP_LOOP_EN
              start_freqw_q <= START_FREQW;
`endif
            end
          end
          INIT: init_dds <= 1'b1;
          LOAD: begin
            freqw   <= cur_freqw;
            update  <= 1'b1;
            req_cnt <= '0;
          end
          REQ: begin
            if (state_nxt == WACK) update <= 1'b0;
            else                   req_cnt <= req_cnt + REQ_CNT_W'(1);
          end
          WDONE: if (dds.UPDATED) begin
            STEP_IDX  <= k;
            STEP_TRIG <= 1'b1;
          end
          NEXT: begin
            if (!last_step) begin
              k         <= k + CNT_W'(1);
              cur_freqw <= cur_freqw + step_freqw_q;
            end
`ifdef SWEEP_LOOP_EN
            else if (LOOP) begin
              k         <= '0;
              cur_freqw <= start_freqw_q;
            end
`endif
          end
          FINISH: begin
            DONE <= 1'b1;
            BUSY <= 1'b0;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_dds_sweep_scheduler.sv
// Directed bench for dds_sweep_scheduler with a behavioural AD9911 updater model
// (2-cycle idle poll, 40-cycle transaction, INITIED 100 cycles after INIT_DDS).
module tb_dds_sweep_scheduler;
  import dds_sweep_pkg::*;

  localparam int CNT_W = 16, DWELL_W = 24, TIMEOUT_CYC = 200;
  localparam int W_DONE = 0, W_UPD_HI = 1, W_UPD_LO = 2, W_TRIG = 3;

  logic               CLOCK_10M = 1'b0, RESET_N = 1'b0;
  logic               START = 1'b0, ABORT = 1'b0;
  logic [31:0]        START_FREQW = '0, STEP_FREQW = '0;
  logic [CNT_W-1:0]   NUM_STEPS = '0;
  logic [DWELL_W-1:0] DWELL_CYC = '0;
`ifdef SWEEP_LOOP_EN
  logic               LOOP = 1'b0;
`endif
  logic               BUSY, STEP_TRIG, DONE, ERROR;
  logic [CNT_W-1:0]   STEP_IDX;

  dds_sweep_scheduler_if dds();

  dds_sweep_scheduler #(.CNT_W(CNT_W), .DWELL_W(DWELL_W), .TIMEOUT_CYC(TIMEOUT_CYC)) dut (
    .CLOCK_10M   (CLOCK_10M),
    .RESET_N     (RESET_N),
    .START       (START),
    .ABORT       (ABORT),
    .START_FREQW (START_FREQW),
    .STEP_FREQW  (STEP_FREQW),
    .NUM_STEPS   (NUM_STEPS),
    .DWELL_CYC   (DWELL_CYC),
`ifdef SWEEP_LOOP_EN
    .LOOP        (LOOP),
`endif
    .dds         (dds),
    .BUSY        (BUSY),
    .STEP_IDX    (STEP_IDX),
    .STEP_TRIG   (STEP_TRIG),
    .DONE        (DONE),
    .ERROR       (ERROR)
  );

  always #50 CLOCK_10M = ~CLOCK_10M;

  // Updater model
  logic        model_hang = 1'b0;
  logic        poll;
  int          init_cnt, busy_m, init_done_count = 0;
  logic [31:0] word_m;
  logic [31:0] word_log[$];

  always @(posedge CLOCK_10M) begin
    if (!RESET_N || !dds.INIT_DDS) begin
      dds.INITIED <= 1'b0;
      dds.UPDATED <= 1'b0;
      init_cnt    <= 0;
      busy_m      <= 0;
      poll        <= 1'b0;
    end else if (!dds.INITIED) begin
      init_cnt <= init_cnt + 1;
      if (init_cnt == 99) begin
        dds.INITIED <= 1'b1;
        init_done_count++;
      end
    end else begin
      poll <= ~poll;
      if (busy_m != 0) begin
        busy_m <= busy_m - 1;
        if (busy_m == 1 && !model_hang) begin
          dds.UPDATED <= 1'b1;
          word_log.push_back(word_m);
        end
      end else if (poll && dds.UPDATE) begin
        dds.UPDATED <= 1'b0;
        word_m      <= dds.FREQW;
        busy_m      <= 40;
      end
    end
  end

  // Output monitors, sampled on the falling edge
  int               upd_len = 0, upd_pulses = 0, upd_bad = 0, trig_cnt = 0, done_cnt = 0;
  logic [CNT_W-1:0] idx_log[$];

  always @(negedge CLOCK_10M) begin
    if (dds.UPDATE === 1'b1) upd_len++;
    else if (upd_len != 0) begin
      upd_pulses++;
      if (upd_len != UPDATE_HOLD) upd_bad++;
      upd_len = 0;
    end
    if (STEP_TRIG === 1'b1) begin
      trig_cnt++;
      idx_log.push_back(STEP_IDX);
    end
    if (DONE === 1'b1) done_cnt++;
  end

  int n_checks = 0, n_pass = 0, n_fail = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge CLOCK_10M);
    #1;
  endtask

  function automatic logic sig(input int sel);
    case (sel)
      W_DONE:   return DONE;
      W_UPD_HI: return dds.UPDATE;
      W_UPD_LO: return !dds.UPDATE;
      W_TRIG:   return STEP_TRIG;
      default:  return 1'b0;
    endcase
  endfunction

  task automatic wait_sig(input int sel, input int max_cyc, input string tag);
    int  c   = 0;
    logic hit = 1'b0;
    while (!hit && c < max_cyc) begin
      tick();
      c++;
      hit = sig(sel);
    end
    check(tag, hit, 1);
  endtask

  function automatic logic [31:0] word_at(input int i);
    return (word_log.size() > i) ? word_log[i] : 32'hDEAD_BEEF;
  endfunction

  function automatic logic [CNT_W-1:0] idx_at(input int i);
    return (idx_log.size() > i) ? idx_log[i] : '1;
  endfunction

  task automatic start_sweep(input logic [31:0] f, input logic [31:0] s, input int n, input int d);
    START_FREQW = f;
    STEP_FREQW  = s;
    NUM_STEPS   = CNT_W'(n);
    DWELL_CYC   = DWELL_W'(d);
    START       = 1'b1;
    tick();
    START       = 1'b0;
  endtask

  initial begin
    #(100 * 40000);
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int d_done, d_trig, d_upd, d_init, c;

    // Reset values
    repeat (3) tick();
    check("rst_init_dds", dds.INIT_DDS, 0);
    check("rst_freqw", dds.FREQW, 0);
    check("rst_update", dds.UPDATE, 0);
    check("rst_busy", BUSY, 0);
    check("rst_step_idx", STEP_IDX, 0);
    check("rst_step_trig", STEP_TRIG, 0);
    check("rst_done", DONE, 0);
    check("rst_error", ERROR, 0);
    RESET_N = 1'b1;
    tick();

    // 1: three-step sweep with dwell
    word_log.delete(); idx_log.delete();
    d_done = done_cnt; d_trig = trig_cnt; d_upd = upd_pulses;
    start_sweep(1000, 10, 3, 5);
    check("t1_busy", BUSY, 1);
    wait_sig(W_DONE, 3000, "t1_done_seen");
    check("t1_nwords", word_log.size(), 3);
    check("t1_w0", word_at(0), 1000);
    check("t1_w1", word_at(1), 1010);
    check("t1_w2", word_at(2), 1020);
    check("t1_trigs", trig_cnt - d_trig, 3);
    check("t1_idx0", idx_at(0), 0);
    check("t1_idx1", idx_at(1), 1);
    check("t1_idx2", idx_at(2), 2);
    check("t1_upd_pulses", upd_pulses - d_upd, 3);
    check("t1_upd_len_bad", upd_bad, 0);
    check("t1_busy_end", BUSY, 0);
    tick();
    check("t1_done_1cyc", DONE, 0);
    check("t1_done_cnt", done_cnt - d_done, 1);
    check("t1_freqw_hold", dds.FREQW, 1020);
    check("t1_init_kept", dds.INIT_DDS, 1);

    // 2a: tuning word wraps; init skipped so first UPDATE is 2 cycles after START
    word_log.delete();
    start_sweep(32'hFFFF_FFF0, 32'h20, 2, 0);
    tick();
    check("t2_lat_early", dds.UPDATE, 0);
    tick();
    check("t2_lat_2cyc", dds.UPDATE, 1);
    wait_sig(W_DONE, 3000, "t2a_done_seen");
    check("t2a_w0", word_at(0), 32'hFFFF_FFF0);
    check("t2a_w1", word_at(1), 32'h0000_0010);

    // 2b: negative step, zero dwell
    word_log.delete(); idx_log.delete();
    start_sweep(20, 32'hFFFF_FFFB, 3, 0);
    wait_sig(W_DONE, 3000, "t2b_done_seen");
    check("t2b_nwords", word_log.size(), 3);
    check("t2b_w0", word_at(0), 20);
    check("t2b_w1", word_at(1), 15);
    check("t2b_w2", word_at(2), 10);
    check("t2b_idx2", idx_at(2), 2);

    // 3: zero steps
    d_upd = upd_pulses;
    start_sweep(77, 1, 0, 0);
    check("t3_done_next", DONE, 1);
    check("t3_busy", BUSY, 0);
    tick();
    check("t3_done_1cyc", DONE, 0);
    repeat (5) tick();
    check("t3_no_update", upd_pulses - d_upd + upd_len, 0);
    check("t3_busy_later", BUSY, 0);

    // 4: abort during WDONE of the second step
    d_done = done_cnt; d_trig = trig_cnt;
    start_sweep(5000, 100, 3, 5);
    wait_sig(W_TRIG, 3000, "t4_first_trig");
    wait_sig(W_UPD_HI, 100, "t4_second_req");
    wait_sig(W_UPD_LO, 10, "t4_req_end");
    repeat (10) tick();
    ABORT = 1'b1;
    tick();
    ABORT = 1'b0;
    check("t4_init_dds_low", dds.INIT_DDS, 0);
    check("t4_busy_low", BUSY, 0);
    check("t4_update_low", dds.UPDATE, 0);
    repeat (60) tick();
    check("t4_no_done", done_cnt - d_done, 0);
    check("t4_one_trig", trig_cnt - d_trig, 1);
    word_log.delete();
    d_init = init_done_count;
    start_sweep(7000, 1, 2, 0);
    wait_sig(W_DONE, 3000, "t4_rerun_done");
    check("t4_reinit", init_done_count - d_init, 1);
    check("t4_rerun_w0", word_at(0), 7000);
    check("t4_rerun_w1", word_at(1), 7001);

    // 5: updater never completes -> timeout in WDONE
    model_hang = 1'b1;
    d_done = done_cnt;
    start_sweep(300, 1, 1, 0);
    wait_sig(W_UPD_HI, 500, "t5_req");
    wait_sig(W_UPD_LO, 10, "t5_req_end");
    c = 0;
    while (ERROR !== 1'b1 && c < 400) begin
      tick();
      c++;
    end
    check("t5_err_cycles", c, TIMEOUT_CYC + 1);
    check("t5_error", ERROR, 1);
    check("t5_init_dds_low", dds.INIT_DDS, 0);
    check("t5_busy_low", BUSY, 0);
    check("t5_no_done", done_cnt - d_done, 0);
    model_hang = 1'b0;
    word_log.delete();
    start_sweep(400, 1, 1, 0);
    check("t5_error_cleared", ERROR, 0);
    wait_sig(W_DONE, 3000, "t5_recover_done");
    check("t5_recover_w0", word_at(0), 400);

`ifdef SWEEP_LOOP_EN
    // 6: looping sweep A,B,A,B then stop after the next B
    word_log.delete();
    d_done = done_cnt;
    LOOP = 1'b1;
    start_sweep(100, 100, 2, 3);
    c = 0;
    while (word_log.size() < 3 && c < 3000) begin
      tick();
      c++;
    end
    check("t6_looping", word_log.size() >= 3, 1);
    check("t6_no_done_loop", done_cnt - d_done, 0);
    LOOP = 1'b0;
    wait_sig(W_DONE, 3000, "t6_done_seen");
    check("t6_nwords", word_log.size(), 4);
    check("t6_w0", word_at(0), 100);
    check("t6_w1", word_at(1), 200);
    check("t6_w2", word_at(2), 100);
    check("t6_w3", word_at(3), 200);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
